// File: rtl/core_pkg.sv
// Shared definitions for the memory-access stage: funct3 memory-op encodings,
// FSM state type, trap causes, entry structs and alignment helpers.
package core_pkg;

    localparam logic [2:0] MemOpB  = 3'b000;
    localparam logic [2:0] MemOpH  = 3'b001;
    localparam logic [2:0] MemOpW  = 3'b010;
    localparam logic [2:0] MemOpBu = 3'b100;
    localparam logic [2:0] MemOpHu = 3'b101;

    localparam logic [31:0] CauseLoadMisaligned  = 32'd4;
    localparam logic [31:0] CauseStoreMisaligned = 32'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } ma_state_t;

    // Memory entry latched when a bus request is launched.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  op;
        logic        is_store;
        logic [4:0]  rd;
        logic        reg_write;
        logic [11:0] csr;
        logic        csr_write;
    } em_entry_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] wdata;
        logic        mem_data_valid;
        logic [11:0] csr;
        logic        csr_write;
        logic [31:0] csr_data;
    } mw_entry_t;

    // Byte offset inside the word; low bits below the access size are dropped.
    function automatic logic [1:0] eff_offset(logic [2:0] op, logic [1:0] a);
        logic [1:0] off;
        case (op)
            MemOpB, MemOpBu: off = a;
            MemOpH, MemOpHu: off = {a[1], 1'b0};
            default:         off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic is_misaligned(logic [2:0] op, logic [1:0] a);
        logic mis;
        case (op)
            MemOpB, MemOpBu: mis = 1'b0;
            MemOpH, MemOpHu: mis = a[0];
            default:         mis = |a;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_ma_if.sv
// EX/MEM entry, data bus and MA/WB signal bundle of the memory-access stage.
// slave: the core_ma side; master: the surrounding pipeline / bus side.
interface core_ma_if;
    import core_pkg::*;

    logic        em_valid;
    logic        em_ready;
    logic [31:0] em_reg_data_mem_addr;
    logic [31:0] em_csr_data_mem_data;
    logic        em_mem_read;
    logic        em_mem_write;
    logic [2:0]  em_mem_op_type;
    logic [4:0]  em_rd;
    logic        em_reg_write;
    logic [11:0] em_csr;
    logic        em_csr_write;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_rdata_valid;
    logic [31:0] bus_rdata;

    logic        mw_valid;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic [31:0] mw_reg_write_data;
    logic        mw_mem_data_valid;
    logic [11:0] mw_csr;
    logic        mw_csr_write;
    logic [31:0] mw_csr_data;

    logic        ma_exception_valid;
    logic [31:0] ma_exception_cause;

    modport slave (
        input  em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
        input  em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
        output em_ready,
        output bus_req_valid, bus_write, bus_addr, bus_wdata, bus_byte_en,
        input  bus_req_ready, bus_rdata_valid, bus_rdata,
        output mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid,
        output mw_csr, mw_csr_write, mw_csr_data,
        output ma_exception_valid, ma_exception_cause
    );

    modport master (
        output em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
        output em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
        input  em_ready,
        input  bus_req_valid, bus_write, bus_addr, bus_wdata, bus_byte_en,
        output bus_req_ready, bus_rdata_valid, bus_rdata,
        input  mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid,
        input  mw_csr, mw_csr_write, mw_csr_data,
        input  ma_exception_valid, ma_exception_cause
    );

endinterface

// File: rtl/core_ma_align.sv
// Combinational lane logic: store byte strobes and lane-replicated write data,
// load data shift-down and sign/zero extension.
module core_ma_align
    import core_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext
);

    logic [1:0]  w_off;
    logic [31:0] w_shifted;

    assign w_off     = eff_offset(i_op, i_addr_lo);
    assign w_shifted = i_rdata >> {w_off, 3'b000};

    // Per-size lane selection and extension.
    always_comb begin
        o_byte_en   = 4'b1111;
        o_wdata     = i_wdata;
        o_rdata_ext = w_shifted;
        case (i_op)
            MemOpB, MemOpBu: begin
                o_byte_en   = 4'b0001 << w_off;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_shifted[7] & ~i_op[2]}}, w_shifted[7:0]};
            end
            MemOpH, MemOpHu: begin
                o_byte_en   = w_off[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_wdata[15:0]}};
                o_rdata_ext = {{16{w_shifted[15] & ~i_op[2]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_ma.sv
// Memory-access pipeline stage: retires ALU entries in one cycle, runs loads and
// stores over a valid/ready request bus with a separate load-data return.
// Optional macro CORE_MA_MISALIGN_CHECK_EN enables misaligned-access traps.
module core_ma
    import core_pkg::*;
(
    input logic     clk,
    input logic     rest,
    core_ma_if.slave io_ma
);

    ma_state_t r_state, w_state_next;
    em_entry_t r_ent, w_ent_in;
    mw_entry_t r_mw, w_mw_next;
    logic      r_mw_valid;
    logic      w_is_mem, w_misaligned, w_capture, w_retire, w_ready_raw, w_req;
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata, w_rdata_ext;

    assign w_is_mem = io_ma.em_mem_read | io_ma.em_mem_write;
    assign w_ent_in = '{
        addr:      io_ma.em_reg_data_mem_addr,
        data:      io_ma.em_csr_data_mem_data,
        op:        io_ma.em_mem_op_type,
        is_store:  io_ma.em_mem_write,
        rd:        io_ma.em_rd,
        reg_write: io_ma.em_reg_write,
        csr:       io_ma.em_csr,
        csr_write: io_ma.em_csr_write
    };

`ifdef CORE_MA_MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(io_ma.em_mem_op_type, io_ma.em_reg_data_mem_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    core_ma_align u_align (
        .i_op        (r_ent.op),
        .i_addr_lo   (r_ent.addr[1:0]),
        .i_wdata     (r_ent.data),
        .i_rdata     (io_ma.bus_rdata),
        .o_byte_en   (w_byte_en),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_rdata_ext)
    );

    // Next state, handshake and retirement payload.
    always_comb begin
        w_state_next = r_state;
        w_ready_raw  = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        w_mw_next    = '{
            rd:             r_ent.rd,
            reg_write:      1'b0,
            wdata:          r_ent.addr,
            mem_data_valid: 1'b0,
            csr:            r_ent.csr,
            csr_write:      r_ent.csr_write,
            csr_data:       r_ent.data
        };
        case (r_state)
            StIdle: begin
                w_mw_next = '{
                    rd:             io_ma.em_rd,
                    reg_write:      io_ma.em_reg_write & ~w_is_mem,
                    wdata:          io_ma.em_reg_data_mem_addr,
                    mem_data_valid: 1'b0,
                    csr:            io_ma.em_csr,
                    csr_write:      io_ma.em_csr_write,
                    csr_data:       io_ma.em_csr_data_mem_data
                };
                if (io_ma.em_valid) begin
                    // Misaligned accesses retire here without touching the bus.
                    if (!w_is_mem || w_misaligned) begin
                        w_ready_raw = 1'b1;
                        w_retire    = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = StReq;
                    end
                end
            end
            StReq: begin
                if (io_ma.bus_req_ready) begin
                    if (r_ent.is_store) begin
                        w_ready_raw  = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                w_mw_next.reg_write      = r_ent.reg_write;
                w_mw_next.wdata          = w_rdata_ext;
                w_mw_next.mem_data_valid = 1'b1;
                if (io_ma.bus_rdata_valid) begin
                    w_ready_raw  = 1'b1;
                    w_retire     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Latch the memory entry so the bus request stays stable while stalled.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest)          r_ent <= '0;
        else if (w_capture) r_ent <= w_ent_in;
    end

    // MA/WB output register; mw_valid is a single-cycle pulse per retirement.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_mw_valid <= 1'b0;
            r_mw       <= '0;
        end else begin
            r_mw_valid <= w_retire;
            if (w_retire) r_mw <= w_mw_next;
        end
    end

`ifdef CORE_MA_MISALIGN_CHECK_EN
    logic        r_exc_valid;
    logic [31:0] r_exc_cause;

    // A memory entry retiring from IDLE can only be a misaligned trap.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
        end else begin
            r_exc_valid <= w_retire && (r_state == StIdle) && w_is_mem;
            if (w_retire && (r_state == StIdle) && w_is_mem) begin
                r_exc_cause <= io_ma.em_mem_write ? CauseStoreMisaligned : CauseLoadMisaligned;
            end
        end
    end

    assign io_ma.ma_exception_valid = r_exc_valid;
    assign io_ma.ma_exception_cause = r_exc_cause;
`else
    assign io_ma.ma_exception_valid = 1'b0;
    assign io_ma.ma_exception_cause = '0;
`endif

    // em_ready is combinational, so gate it to honour reset immediately.
    assign w_req                   = (r_state == StReq);
    assign io_ma.em_ready          = w_ready_raw & rest;
    assign io_ma.bus_req_valid     = w_req;
    assign io_ma.bus_write         = w_req & r_ent.is_store;
    assign io_ma.bus_addr          = w_req ? {r_ent.addr[31:2], 2'b00} : 32'd0;
    assign io_ma.bus_wdata         = w_req ? w_wdata : 32'd0;
    assign io_ma.bus_byte_en       = w_req ? w_byte_en : 4'd0;

    assign io_ma.mw_valid          = r_mw_valid;
    assign io_ma.mw_rd             = r_mw.rd;
    assign io_ma.mw_reg_write      = r_mw.reg_write;
    assign io_ma.mw_reg_write_data = r_mw.wdata;
    assign io_ma.mw_mem_data_valid = r_mw.mem_data_valid;
    assign io_ma.mw_csr            = r_mw.csr;
    assign io_ma.mw_csr_write      = r_mw.csr_write;
    assign io_ma.mw_csr_data       = r_mw.csr_data;

endmodule

// File: tb/tb_core_ma.sv
// Self-checking bench for core_ma: directed cases plus randomized ALU/load/store
// traffic checked against an arithmetic model of lane selection and extension.
module tb_core_ma;

    logic clk = 1'b0;
    logic rest;
    always #5 clk = ~clk;

    core_ma_if u_if ();

    core_ma u_dut (
        .clk   (clk),
        .rest  (rest),
        .io_ma (u_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] op);
        case (op[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int op_off(input logic [2:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        return lo - (lo % op_size(op));
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [31:0] a);
        return (int'(a % 4) % op_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_byte_en(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] be;
        int off = op_off(op, a);
        int sz  = op_size(op);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] w;
        int sz = op_size(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint one = 1;
        longint v   = {32'd0, rd};
        int sz = op_size(op);
        v = v >> (8 * op_off(op, a));
        v = v & ((one << (8 * sz)) - 1);
        if (!op[2] && v >= (one << (8 * sz - 1))) v = v - (one << (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_entry(input logic [31:0] a, input logic [31:0] d, input logic rd_l,
                               input logic wr, input logic [2:0] op, input logic [4:0] rd,
                               input logic rw, input logic [11:0] csr, input logic cw);
        u_if.em_valid             = 1'b1;
        u_if.em_reg_data_mem_addr = a;
        u_if.em_csr_data_mem_data = d;
        u_if.em_mem_read          = rd_l;
        u_if.em_mem_write         = wr;
        u_if.em_mem_op_type       = op;
        u_if.em_rd                = rd;
        u_if.em_reg_write         = rw;
        u_if.em_csr               = csr;
        u_if.em_csr_write         = cw;
    endtask

    task automatic check_mw(input logic [4:0] rd, input logic rw, input logic [31:0] wd,
                            input logic mdv, input logic [11:0] csr, input logic cw,
                            input logic [31:0] cd);
        check("mw_valid", 32'(u_if.mw_valid), 32'd1);
        check("mw_rd", 32'(u_if.mw_rd), 32'(rd));
        check("mw_reg_write", 32'(u_if.mw_reg_write), 32'(rw));
        check("mw_reg_write_data", u_if.mw_reg_write_data, wd);
        check("mw_mem_data_valid", 32'(u_if.mw_mem_data_valid), 32'(mdv));
        check("mw_csr", 32'(u_if.mw_csr), 32'(csr));
        check("mw_csr_write", 32'(u_if.mw_csr_write), 32'(cw));
        check("mw_csr_data", u_if.mw_csr_data, cd);
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [31:0] cd, input logic [4:0] rd,
                          input logic rw, input logic [11:0] csr, input logic cw);
        @(negedge clk);
        drive_entry(res, cd, 1'b0, 1'b0, 3'd2, rd, rw, csr, cw);
        #1;
        check("alu_em_ready", 32'(u_if.em_ready), 32'd1);
        check("alu_no_bus_req", 32'(u_if.bus_req_valid), 32'd0);
        @(negedge clk);
        u_if.em_valid = 1'b0;
        #1;
        check_mw(rd, rw, res, 1'b0, csr, cw, cd);
        check("alu_no_exc", 32'(u_if.ma_exception_valid), 32'd0);
        @(negedge clk);
        #1;
        check("alu_mw_pulse", 32'(u_if.mw_valid), 32'd0);
    endtask

    task automatic check_req(input logic st, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] d);
        check("req_valid", 32'(u_if.bus_req_valid), 32'd1);
        check("req_write", 32'(u_if.bus_write), 32'(st));
        check("req_addr", u_if.bus_addr, {a[31:2], 2'b00});
        if (st) begin
            check("req_byte_en", 32'(u_if.bus_byte_en), 32'(m_byte_en(op, a)));
            check("req_wdata", u_if.bus_wdata, m_wdata(op, d));
        end
    endtask

    task automatic do_mem(input logic ld, input logic st, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input logic rw, input logic [11:0] csr, input logic cw,
                          input int ready_dly, input int rdata_dly, input logic [31:0] rdata);
        logic exc;
`ifdef CORE_MA_MISALIGN_CHECK_EN
        exc = op_misaligned(op, a);
`else
        exc = 1'b0;
`endif
        @(negedge clk);
        drive_entry(a, d, ld, st, op, rd, rw, csr, cw);
        #1;
        if (exc) begin
            check("exc_em_ready", 32'(u_if.em_ready), 32'd1);
            check("exc_no_bus_req", 32'(u_if.bus_req_valid), 32'd0);
            @(negedge clk);
            u_if.em_valid = 1'b0;
            #1;
            check_mw(rd, 1'b0, a, 1'b0, csr, cw, d);
            check("exc_valid", 32'(u_if.ma_exception_valid), 32'd1);
            check("exc_cause", u_if.ma_exception_cause, st ? 32'd6 : 32'd4);
            check("exc_no_bus_req2", 32'(u_if.bus_req_valid), 32'd0);
            @(negedge clk);
            #1;
            check("exc_pulse", 32'(u_if.ma_exception_valid), 32'd0);
            return;
        end
        check("mem_em_ready_idle", 32'(u_if.em_ready), 32'd0);
        for (int i = 0; i < ready_dly; i++) begin
            @(negedge clk);
            #1;
            check_req(st, op, a, d);
            check("req_stall_em_ready", 32'(u_if.em_ready), 32'd0);
        end
        @(negedge clk);
        u_if.bus_req_ready   = 1'b1;
        u_if.bus_rdata_valid = 1'b1;      // stray return in REQ must be ignored
        u_if.bus_rdata       = ~rdata;
        #1;
        check_req(st, op, a, d);
        check("handshake_em_ready", 32'(u_if.em_ready), 32'(st));
        @(negedge clk);
        u_if.bus_req_ready   = 1'b0;
        u_if.bus_rdata_valid = 1'b0;
        if (st) begin
            u_if.em_valid = 1'b0;
            #1;
            check_mw(rd, 1'b0, a, 1'b0, csr, cw, d);
            check("store_req_dropped", 32'(u_if.bus_req_valid), 32'd0);
            check("store_no_exc", 32'(u_if.ma_exception_valid), 32'd0);
            return;
        end
        #1;
        check("wait_req_dropped", 32'(u_if.bus_req_valid), 32'd0);
        check("wait_no_mw", 32'(u_if.mw_valid), 32'd0);
        check("wait_em_ready", 32'(u_if.em_ready), 32'd0);
        for (int i = 0; i < rdata_dly; i++) begin
            @(negedge clk);
            #1;
            check("wait_stall_em_ready", 32'(u_if.em_ready), 32'd0);
        end
        u_if.bus_rdata_valid = 1'b1;
        u_if.bus_rdata       = rdata;
        #1;
        check("load_em_ready", 32'(u_if.em_ready), 32'd1);
        @(negedge clk);
        u_if.bus_rdata_valid = 1'b0;
        u_if.em_valid        = 1'b0;
        #1;
        check_mw(rd, rw, m_load(op, a, rdata), 1'b1, csr, cw, d);
        check("load_no_exc", 32'(u_if.ma_exception_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [2:0] ld_ops [5];

    initial begin
        ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rest                 = 1'b0;
        u_if.bus_req_ready   = 1'b0;
        u_if.bus_rdata_valid = 1'b0;
        u_if.bus_rdata       = '0;
        drive_entry(32'h55, 32'h66, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 12'h300, 1'b1);
        #1;
        check("rst_em_ready", 32'(u_if.em_ready), 32'd0);
        check("rst_bus_req_valid", 32'(u_if.bus_req_valid), 32'd0);
        check("rst_bus_addr", u_if.bus_addr, 32'd0);
        check("rst_mw_valid", 32'(u_if.mw_valid), 32'd0);
        check("rst_mw_data", u_if.mw_reg_write_data, 32'd0);
        check("rst_exc", 32'(u_if.ma_exception_valid), 32'd0);
        @(negedge clk);
        u_if.em_valid = 1'b0;
        rest          = 1'b1;

        // ALU 0x1234 to x5
        do_alu(32'h1234, 32'h0, 5'd5, 1'b1, 12'h000, 1'b0);
        // LB / LBU at 0x103 with rdata 0x80FFFFFF
        do_mem(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd6, 1'b1, 12'h0, 1'b0, 0, 1, 32'h80FFFFFF);
        do_mem(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 5'd7, 1'b1, 12'h0, 1'b0, 1, 0, 32'h80FFFFFF);
        // SH at 0x102, ready held low 3 cycles
        do_mem(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000ABCD, 5'd8, 1'b1, 12'h0, 1'b0, 3, 0, 32'h0);
        // Read+write together behaves as a store
        do_mem(1'b1, 1'b1, 3'd0, 32'h201, 32'h000000A5, 5'd9, 1'b1, 12'h341, 1'b1, 0, 0, 32'h0);
        // LW at 0x101: trap when checking is on, else low bits ignored
        do_mem(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd10, 1'b1, 12'h0, 1'b0, 0, 0, 32'hDEADBEEF);

        // Reset while a load waits for data
        @(negedge clk);
        drive_entry(32'h200, 32'h0, 1'b1, 1'b0, 3'd2, 5'd11, 1'b1, 12'h0, 1'b0);
        @(negedge clk);
        u_if.bus_req_ready = 1'b1;
        @(negedge clk);
        u_if.bus_req_ready = 1'b0;
        rest               = 1'b0;
        #1;
        check("wait_rst_em_ready", 32'(u_if.em_ready), 32'd0);
        check("wait_rst_req", 32'(u_if.bus_req_valid), 32'd0);
        check("wait_rst_mw_rd", 32'(u_if.mw_rd), 32'd0);
        @(negedge clk);
        rest                 = 1'b1;
        u_if.em_valid        = 1'b0;
        u_if.bus_rdata_valid = 1'b1;
        u_if.bus_rdata       = 32'h12345678;
        #1;
        check("post_rst_em_ready", 32'(u_if.em_ready), 32'd0);
        @(negedge clk);
        u_if.bus_rdata_valid = 1'b0;
        #1;
        check("post_rst_no_mw", 32'(u_if.mw_valid), 32'd0);
        check("post_rst_no_req", 32'(u_if.bus_req_valid), 32'd0);
        do_alu(32'hCAFE0001, 32'h77, 5'd12, 1'b1, 12'h305, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int unsigned kind = $urandom_range(0, 2);
            logic [31:0] a  = $urandom;
            logic [31:0] d  = $urandom;
            logic [31:0] rv = $urandom;
            logic [4:0]  rd = 5'($urandom);
            logic        rw = 1'($urandom);
            logic [11:0] cs = 12'($urandom);
            logic        cw = 1'($urandom);
            int          r1 = int'($urandom_range(0, 3));
            int          r2 = int'($urandom_range(0, 3));
            if (kind == 0) begin
                do_alu(a, d, rd, rw, cs, cw);
            end else if (kind == 1) begin
                do_mem(1'b1, 1'b0, ld_ops[$urandom_range(0, 4)], a, d, rd, rw, cs, cw, r1, r2, rv);
            end else begin
                do_mem(1'($urandom), 1'b1, 3'($urandom_range(0, 2)), a, d, rd, rw, cs, cw,
                       r1, r2, rv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ma.md
CORE_MA -- requirements
Module: core_ma

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; rest in 1, asynchronous active-low reset.
REQ-002 em_valid  in  1  EX/MEM entry valid.
REQ-003 em_ready  out  1  entry consumed this cycle.
REQ-004 em_reg_data_mem_addr  in  32  ALU result or memory byte address.
REQ-005 em_csr_data_mem_data  in  32  CSR write data or store data.
REQ-006 em_mem_read  in  1  load.
REQ-007 em_mem_write  in  1  store.
REQ-008 em_mem_op_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 em_rd  in  5  destination register.
REQ-010 em_reg_write  in  1  register write enable.
REQ-011 em_csr  in  12  CSR address.
REQ-012 em_csr_write  in  1  CSR write enable.
REQ-013 bus_req_valid  out  1  bus request valid.
REQ-014 bus_req_ready  in  1  bus accepts request.
REQ-015 bus_write  out  1  1 = store, 0 = load.
REQ-016 bus_addr  out  32  word address, bits [1:0] = 0.
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_byte_en  out  4  byte lane strobes.
REQ-019 bus_rdata_valid  in  1  load data return.
REQ-020 bus_rdata  in  32  load data word.
REQ-021 mw_valid  out  1  MA/WB entry valid, one-cycle pulse per retired entry.
REQ-022 mw_rd  out  5  destination register.
REQ-023 mw_reg_write  out  1  register write enable.
REQ-024 mw_reg_write_data  out  32  ALU result or extended load data.
REQ-025 mw_mem_data_valid  out  1  mw_reg_write_data is load data.
REQ-026 mw_csr  out  12  CSR address.
REQ-027 mw_csr_write  out  1  CSR write enable.
REQ-028 mw_csr_data  out  32  CSR write data.
REQ-029 ma_exception_valid  out  1  misaligned access, one-cycle pulse.
REQ-030 ma_exception_cause  out  32  4 = load misaligned, 6 = store misaligned.

Function
REQ-031 The FSM SHALL use three states: IDLE, REQ, WAIT.
- Non-memory entry in IDLE: em_ready=1 in the same cycle; mw_* registered on the next edge; latency 1.
REQ-032 A memory entry in IDLE SHALL move the FSM to REQ with em_ready=0.
- REQ: bus_req_valid=1, with bus_addr, bus_write, bus_byte_en and bus_wdata held stable until bus_req_ready.
- Store: on handshake, em_ready=1, mw_valid pulses, FSM goes to IDLE.
- Load: on handshake, FSM goes to WAIT.
REQ-033 In WAIT, bus_rdata_valid SHALL set em_ready=1 and mw_mem_data_valid=1, load mw_reg_write_data with the extracted data, and return the FSM to IDLE.
- bus_rdata_valid outside WAIT is ignored, including in the REQ handshake cycle.
REQ-034 Alignment rules:
- Store byte_en: B = 1<<a[1:0]; H = 0011/1100 by a[1]; W = 1111.
- Store wdata: byte replicated x4, halfword replicated x2.
- Load: rdata >> (8*a[1:0]); B/H sign-extended, BU/HU zero-extended.
REQ-035 mw_csr, mw_csr_write and mw_csr_data SHALL pass through with the entry; for stores, mw_reg_write is 0.
REQ-036 An entry with both em_mem_read and em_mem_write set SHALL be treated as a store.

Reset
REQ-037 rest low SHALL force the FSM to IDLE and all outputs to 0 immediately, abandoning any in-flight request; the next transaction starts from IDLE.

Configuration
REQ-038 Misaligned-access checking SHALL be controlled by macro CORE_MA_MISALIGN_CHECK_EN.
- Defined: H with a[0]!=0, or W with a[1:0]!=0, issues no bus request. ma_exception_valid pulses with cause 4 or 6; mw_valid pulses with mw_reg_write=0; em_ready=1 in IDLE.
- Undefined: ma_exception_* are tied to 0, and the offending low address bits are ignored.

Structure
REQ-039 Package core_pkg SHALL hold the mem_op encodings, the ma_state_t enum and the exception cause constants.
REQ-040 Combinational sub-module core_ma_align SHALL generate byte_en and wdata and perform load extraction/extension.

Verification
REQ-041 ALU entry 0x1234 to x5 -> mw_valid one cycle later, mw_reg_write_data=0x1234, mw_mem_data_valid=0.
REQ-042 LB at 0x103, rdata 0x80FFFFFF -> mw_reg_write_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-043 SH at 0x102, data 0xABCD, bus_req_ready held low 3 cycles -> request stable 4 cycles, byte_en=1100, wdata=0xABCDABCD.
REQ-044 Load in WAIT, rest asserted, then bus_rdata_valid -> FSM in IDLE, no mw_valid.
REQ-045 CORE_MA_MISALIGN_CHECK_EN defined, LW at 0x101 -> no bus_req_valid, ma_exception_valid=1, cause=4.
